pwm_multi_ctrl: RTL

PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

---
 rtl/pwm_multi_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pwm_multi_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_multi_ctrl
//   Multi-channel PWM generator with double-buffered period/duty registers.
//   Each channel owns a period shadow (PS) and duty shadow (DS) written through
//   a shared write port. At every period boundary, and continuously while the
//   channel is disabled, the shadows and the CENTER mode bit are copied into
//   the active registers (PA, DA, MA). A running period therefore never sees a
//   half-applied update.
//
//   Modes:
//     edge-aligned   : CNT counts 0..PA-1 and wraps. The period is PA cycles.
//     center-aligned : CNT counts up 0..PA-1, then down PA-1..0. Each end value
//                      is held for one cycle while DIR turns. The period is
//                      2*PA cycles.
//   PA = 0 means every cycle is a boundary and the output stays at the
//   inactive level.
//
//   Write port handshake: a write is accepted on every rising CLK edge where
//   WR_EN=1. There is no back-pressure. A write to a channel index >= NCH
//   matches no channel and is dropped.
//
// Ports
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset (clears all state to 0)
//   WR_EN        shadow write strobe
//   WR_CH        target channel of the write
//   WR_SEL       0 = period shadow, 1 = duty shadow
//   WR_DATA      write data
//   ENABLE       per-channel run enable
//   CENTER       per-channel mode request (0 edge, 1 center)
//   POL          per-channel polarity (0 active-high, 1 active-low)
//   PWM_OUT      registered PWM outputs
//   PERIOD_TICK  one-cycle pulse following each period boundary
// ---------------------------------------------------------------------------
module pwm_multi_ctrl #(
  parameter int NCH = 4,
  parameter int CW  = 28
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  WR_EN,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] WR_CH,
  input  logic                                  WR_SEL,
  input  logic [CW-1:0]                         WR_DATA,
  input  logic [NCH-1:0]                        ENABLE,
  input  logic [NCH-1:0]                        CENTER,
  input  logic [NCH-1:0]                        POL,
  output logic [NCH-1:0]                        PWM_OUT,
  output logic [NCH-1:0]                        PERIOD_TICK
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Only indices below NCH get a decoder, so out-of-range writes hit nothing.
    localparam logic [CHW-1:0] CH_ID = CHW'(i);

    logic [CW-1:0] ps, ds, pa, da, cnt;
    logic          ma, dir;
    logic          pwm_q, tick_q;

    logic [CW-1:0] pa_m1;
    logic [CW-1:0] cnt_nxt;
    logic          dir_nxt;
    logic          boundary;
    logic          wr_hit;

    assign wr_hit = WR_EN && (WR_CH == CH_ID);
    assign pa_m1  = pa - CW'(1);

    // Next counter/direction and boundary detection for an enabled channel.
    // The ">=" compares keep the counter bounded if it ever exceeds PA-1.
    always_comb begin
      boundary = 1'b0;
      cnt_nxt  = cnt;
      dir_nxt  = dir;
      if (pa == '0) begin
        boundary = 1'b1;
        cnt_nxt  = '0;
        dir_nxt  = 1'b0;
      end else if (!ma) begin
        dir_nxt = 1'b0;
        if (cnt >= pa_m1) begin
          cnt_nxt  = '0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end else if (!dir) begin
        // Reaching the top holds CNT for one cycle while the direction turns.
        if (cnt >= pa_m1) dir_nxt = 1'b1;
        else              cnt_nxt = cnt + CW'(1);
      end else begin
        // Reaching zero going down closes the period.
        if (cnt == '0) begin
          dir_nxt  = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        ps     <= '0;
        ds     <= '0;
        pa     <= '0;
        da     <= '0;
        ma     <= 1'b0;
        cnt    <= '0;
        dir    <= 1'b0;
        pwm_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        // A reload on this same edge sees the old shadow value. The new value
        // waits for the next boundary.
        if (wr_hit && !WR_SEL) ps <= WR_DATA;
        if (wr_hit &&  WR_SEL) ds <= WR_DATA;

        if (!ENABLE[i]) begin
          cnt    <= '0;
          dir    <= 1'b0;
          pa     <= ps;
          da     <= ds;
          ma     <= CENTER[i];
          tick_q <= 1'b0;
          pwm_q  <= POL[i];
        end else begin
          cnt    <= cnt_nxt;
          dir    <= dir_nxt;
          tick_q <= boundary;
          if (boundary) begin
            pa <= ps;
            da <= ds;
            ma <= CENTER[i];
          end
          // The output reflects the counter value before this edge.
          // CNT < PA always holds, so DA >= PA saturates to fully active.
          pwm_q <= (pa == '0) ? POL[i] : ((cnt < da) ^ POL[i]);
        end
      end
    end

    assign PWM_OUT[i]     = pwm_q;
    assign PERIOD_TICK[i] = tick_q;
  end

endmodule
